// File: rtl/inst_mem_pipelined_if.sv
// Fetch/response/load bundle for the pipelined instruction memory.
// The master drives requests, response acceptance and byte loads;
// the slave (the memory) answers with ready, valid, data and fault.
interface inst_mem_pipelined_if #(
  parameter int AW    = 64,
  parameter int DEPTH = 64
);
  logic                     req_valid;
  logic                     req_ready;
  logic [AW-1:0]            req_addr;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [31:0]              resp_inst;
  logic [1:0]               resp_fault;
  logic                     ld_en;
  logic [$clog2(DEPTH)-1:0] ld_addr;
  logic [7:0]               ld_data;

  modport master (
    output req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, resp_valid, resp_inst, resp_fault
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, ld_en, ld_addr, ld_data,
    output req_ready, resp_valid, resp_inst, resp_fault
  );
endinterface

// File: rtl/inst_mem_pipelined.sv
// Byte-addressed instruction memory with a fixed-latency, single-outstanding
// fetch port. The word and its fault bits are captured when the request is
// accepted, then released LATENCY edges later and held until consumed.
module inst_mem_pipelined #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1,
  parameter int AW      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_mem_pipelined_if.slave   bus
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic [1:0]  fault_q, fault_d;

  logic [7:0]    mem [DEPTH];
  logic [IW-1:0] base;
  logic          mis, oor, accept;
  logic [31:0]   word;

  // Byte loads land in any state, reset included; storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (bus.ld_en) mem[bus.ld_addr] <= bus.ld_data;
  end

  assign base = bus.req_addr[IW-1:0];
  assign mis  = (bus.req_addr[1:0] != 2'b00);
  // Compared on the full address so huge addresses never alias back into range.
  assign oor  = (bus.req_addr > AW'(DEPTH - 4));
  // Reads see contents before this edge's load, since the write is non-blocking.
  assign word = {mem[base + IW'(3)], mem[base + IW'(2)],
                 mem[base + IW'(1)], mem[base]};

  // Loads take priority over fetches, so a load cycle never accepts.
  assign bus.req_ready = (state_q == IDLE) && !bus.ld_en && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  // Next-state, latency counter and captured response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          fault_d = {oor, mis};
          inst_d  = (mis || oor) ? 32'h0 : word;
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 3'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          inst_d  = 32'h0;
          fault_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any pending or held response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      inst_q  <= 32'h0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_inst  = bus.resp_valid ? inst_q  : 32'h0;
  assign bus.resp_fault = bus.resp_valid ? fault_q : 2'b00;
endmodule

// File: tb/tb_inst_mem_pipelined.sv
// Bench for inst_mem_pipelined: three instances (LATENCY 1, 2, 4) share the
// load/reset pins and have their own fetch handshakes. Expected data come
// from a byte-array model; expected timing from the LATENCY of each instance.
module tb_inst_mem_pipelined;
  localparam int DEPTH = 64;
  localparam int AW    = 64;
  localparam int IW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst;
  logic ld_en;
  logic [IW-1:0] ld_addr;
  logic [7:0]    ld_data;

  logic [2:0]    rv, rr, rdy, vld;
  logic [AW-1:0] ra [3];
  logic [31:0]   inst_w [3];
  logic [1:0]    flt_w [3];

  logic [7:0] model_mem [DEPTH];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT_G = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    inst_mem_pipelined_if #(.AW(AW), .DEPTH(DEPTH)) bus ();
    assign bus.req_valid  = rv[gi];
    assign bus.req_addr   = ra[gi];
    assign bus.resp_ready = rr[gi];
    assign bus.ld_en      = ld_en;
    assign bus.ld_addr    = ld_addr;
    assign bus.ld_data    = ld_data;
    assign rdy[gi]        = bus.req_ready;
    assign vld[gi]        = bus.resp_valid;
    assign inst_w[gi]     = bus.resp_inst;
    assign flt_w[gi]      = bus.resp_fault;
    inst_mem_pipelined #(.DEPTH(DEPTH), .LATENCY(LAT_G), .AW(AW)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  // Fault: bit0 when not word aligned, bit1 when the 4 bytes do not fit.
  function automatic logic [1:0] exp_fault(input logic [AW-1:0] a);
    logic [AW:0] end_excl;
    end_excl = {1'b0, a} + (AW+1)'(4);
    return {end_excl > (AW+1)'(DEPTH), a[1:0] != 2'b00};
  endfunction

  function automatic logic [31:0] exp_inst(input logic [AW-1:0] a);
    logic [31:0] w;
    int base;
    if (exp_fault(a) != 2'b00) return 32'h0;
    base = int'(a);
    w = 32'h0;
    for (int i = 0; i < 4; i++) w = w | (32'(model_mem[base + i]) << (8 * i));
    return w;
  endfunction

  task automatic load_byte(input int a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = IW'(a); ld_data = d;
    @(negedge clk);
    model_mem[a] = d;
    ld_en = 1'b0;
  endtask

  // Complete one fetch on instance k; hold resp_ready low for 'hold' RESP cycles.
  task automatic do_fetch(input int k, input logic [AW-1:0] addr, input int hold);
    int n;
    logic [31:0] ei, si;
    logic [1:0]  ef, sf;
    ei = exp_inst(addr);
    ef = exp_fault(addr);
    rv[k] = 1'b1; ra[k] = addr;
    #1;
    n = 0;
    while (!rdy[k] && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (!rdy[k]) begin
      errors++;
      $display("FAIL accept_timeout k=%0d addr=%0h ready=%b required 1", k, addr, rdy[k]);
      rv[k] = 1'b0;
      return;
    end
    @(negedge clk);
    rv[k] = 1'b0;
    n = 1;
    while (!vld[k] && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n !== lat_of(k)) begin
      errors++;
      $display("FAIL latency k=%0d addr=%0h got %0d required %0d", k, addr, n, lat_of(k));
    end
    checks++;
    if (inst_w[k] !== ei) begin
      errors++;
      $display("FAIL inst k=%0d addr=%0h got %h required %h", k, addr, inst_w[k], ei);
    end
    checks++;
    if (flt_w[k] !== ef) begin
      errors++;
      $display("FAIL fault k=%0d addr=%0h got %b required %b", k, addr, flt_w[k], ef);
    end
    checks++;
    if (rdy[k] !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_resp k=%0d got %b required 0", k, rdy[k]);
    end
    si = inst_w[k]; sf = flt_w[k];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (vld[k] !== 1'b1 || inst_w[k] !== ei || flt_w[k] !== ef || rdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL hold k=%0d cyc=%0d valid=%b inst=%h fault=%b ready=%b required 1/%h/%b/0",
                 k, h, vld[k], inst_w[k], flt_w[k], rdy[k], ei, ef);
      end
    end
    rr[k] = 1'b1;
    @(negedge clk);
    rr[k] = 1'b0;
    checks++;
    if (vld[k] !== 1'b0 || inst_w[k] !== 32'h0 || flt_w[k] !== 2'b00 || rdy[k] !== 1'b1) begin
      errors++;
      $display("FAIL release k=%0d valid=%b inst=%h fault=%b ready=%b required 0/0/0/1",
               k, vld[k], inst_w[k], flt_w[k], rdy[k]);
    end
    $display("fetch lat=%0d addr=%0h inst=%h fault=%b hold=%0d", lat_of(k), addr, si, sf, hold);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy[k] !== 1'b0 || vld[k] !== 1'b0 || inst_w[k] !== 32'h0 || flt_w[k] !== 2'b00) begin
        errors++;
        $display("FAIL reset_state k=%0d ready=%b valid=%b inst=%h fault=%b required 0/0/0/0",
                 k, rdy[k], vld[k], inst_w[k], flt_w[k]);
      end
    end
    // A load during reset still lands.
    load_byte(20, 8'hA5);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset k=%0d got %b required 1", k, rdy[k]);
      end
    end
    $display("reset released");
  endtask

  task automatic test_fill();
    for (int a = 0; a < DEPTH; a++) if (a < 20 || a > 23) load_byte(a, 8'($urandom));
    $display("memory filled");
  endtask

  task automatic test_basic();
    load_byte(0, 8'h83); load_byte(1, 8'h34); load_byte(2, 8'h05); load_byte(3, 8'h0F);
    do_fetch(1, 64'd0, 0);
    do_fetch(0, 64'd20, 0);
  endtask

  task automatic test_faults();
    do_fetch(1, 64'd2, 0);
    do_fetch(1, 64'(DEPTH - 2), 0);
    do_fetch(1, 64'(DEPTH), 0);
    do_fetch(1, 64'(DEPTH - 4), 0);
    do_fetch(1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    do_fetch(2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
  endtask

  task automatic test_hold();
    do_fetch(1, 64'd16, 3);
  endtask

  task automatic test_ld_block();
    rv[1] = 1'b1; ra[1] = 64'd8; ld_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_addr = IW'(8 + i); ld_data = 8'($urandom);
      @(negedge clk);
      model_mem[8 + i] = ld_data;
      checks++;
      if (rdy[1] !== 1'b0 || vld[1] !== 1'b0) begin
        errors++;
        $display("FAIL ld_block cyc=%0d ready=%b valid=%b required 0/0", i, rdy[1], vld[1]);
      end
    end
    ld_en = 1'b0;
    #1;
    checks++;
    if (rdy[1] !== 1'b1) begin
      errors++;
      $display("FAIL ld_release ready=%b required 1", rdy[1]);
    end
    do_fetch(1, 64'd8, 0);
  endtask

  task automatic test_reset_in_flight();
    // Reset while the LATENCY=2 request waits.
    rv[1] = 1'b1; ra[1] = 64'd12;
    #1;
    if (rdy[1]) begin
      @(negedge clk);
      rv[1] = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        checks++;
        if (vld[1] !== 1'b0) begin
          errors++;
          $display("FAIL wait_discard cyc=%0d valid=%b required 0", i, vld[1]);
        end
      end
    end else begin
      rv[1] = 1'b0;
      checks++; errors++;
      $display("FAIL reset_wait_setup ready=%b required 1", rdy[1]);
    end
    do_fetch(1, 64'd12, 0);
    // Reset while the LATENCY=1 response is held.
    rv[0] = 1'b1; ra[0] = 64'd4;
    @(negedge clk);
    rv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vld[0] !== 1'b0 || inst_w[0] !== 32'h0) begin
        errors++;
        $display("FAIL held_discard cyc=%0d valid=%b inst=%h required 0/0", i, vld[0], inst_w[0]);
      end
      @(negedge clk);
    end
    do_fetch(0, 64'd4, 1);
    $display("reset discard done");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) do_fetch(k, 64'(4 * j), 0);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int k;
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) == 0) load_byte($urandom_range(0, DEPTH - 1), 8'($urandom));
      k = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0: a = 64'($urandom_range(0, DEPTH / 4 - 1) * 4);
        1: a = 64'($urandom_range(0, DEPTH - 1));
        2: a = 64'($urandom_range(DEPTH - 8, DEPTH + 8));
        default: a = {32'($urandom), 32'($urandom)};
      endcase
      do_fetch(k, a, $urandom_range(0, 3));
    end
  endtask

  initial begin
    rv = '0; rr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rst = 1'b1;
    for (int k = 0; k < 3; k++) ra[k] = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_basic();
    test_faults();
    test_hold();
    test_ld_block();
    test_reset_in_flight();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_mem_pipelined.md
INST_MEM_PIPELINED -- requirements
Module: inst_mem_pipelined

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning memory size in bytes (power of 2, at least 8).
REQ-002 SHALL have parameter LATENCY, default 1, meaning cycles from request accept to response valid (1 to 4).
REQ-003 SHALL have parameter AW, default 64, meaning fetch address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: fetch request present.
REQ-007 SHALL have port req_ready, output, 1 bit: block can accept a fetch.
REQ-008 SHALL have port req_addr, input, AW bits: byte address of the instruction.
REQ-009 SHALL have port resp_valid, output, 1 bit: response present.
REQ-010 SHALL have port resp_ready, input, 1 bit: consumer takes the response.
REQ-011 SHALL have port resp_inst, output, 32 bits: fetched instruction.
REQ-012 SHALL have port resp_fault, output, 2 bits: bit0 = misaligned, bit1 = out of range.
REQ-013 SHALL have port ld_en, input, 1 bit: byte load strobe.
REQ-014 SHALL have port ld_addr, input, $clog2(DEPTH) bits: load byte address.
REQ-015 SHALL have port ld_data, input, 8 bits: load byte value.

Function
REQ-016 SHALL use a byte-wide array of DEPTH entries as storage; reset SHALL NOT alter its contents.
REQ-017 SHALL write ld_data to mem[ld_addr] on every rising edge where ld_en=1, in any state.
REQ-018 SHALL implement the states IDLE, WAIT and RESP.
REQ-019 SHALL drive req_ready=1 only in IDLE with ld_en=0; a fetch is accepted on an edge where req_valid=1 and req_ready=1.
REQ-020 SHALL, on accept, capture the instruction and fault from memory contents as they stand before that edge's load write; it SHALL then go to RESP if LATENCY=1, else to WAIT with the counter set to LATENCY-1.
REQ-021 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter reaches 1→0, so resp_valid rises exactly LATENCY edges after the accept edge.
REQ-022 SHALL, in RESP, hold resp_valid=1 and keep resp_inst and resp_fault stable until the edge where resp_ready=1, then return to IDLE with resp_valid=0.
REQ-023 SHALL NOT accept a fetch on the same edge as a RESP handshake; there is one outstanding request maximum.
REQ-024 SHALL assemble instructions little-endian: resp_inst = {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
REQ-025 SHALL set the misaligned fault when req_addr[1:0] != 0.
REQ-026 SHALL set the out-of-range fault when req_addr > DEPTH-4, evaluated on the full AW-bit address with no wrap.
REQ-027 SHALL set resp_inst=32'h00000000 whenever either fault bit is set; both fault bits may be set together.
REQ-028 SHALL keep resp_inst and resp_fault at 0 whenever resp_valid=0.

Reset
REQ-029 SHALL, on any edge with reset=1, set the state to IDLE, the counter to 0, resp_valid=0, resp_inst=0 and resp_fault=0; reset has priority over all other events.
REQ-030 SHALL drive req_ready=0 on any cycle where reset=1.
REQ-031 SHALL discard any in-flight or held response on reset; no response for it SHALL ever appear.
REQ-032 SHALL still perform an ld_en write on an edge where reset=1.

Verification
REQ-033 With LATENCY=2, load bytes 83,34,05,0F at 0-3, then fetch addr 0 → resp_valid 2 edges after accept, resp_inst=32'h0F053483, resp_fault=00.
REQ-034 Fetch addr 2 → resp_fault=01, resp_inst=0; fetch addr DEPTH-2 → resp_fault=11; fetch addr DEPTH → resp_fault=10.
REQ-035 Hold resp_ready=0 for 3 cycles in RESP → resp_valid, resp_inst and resp_fault stay stable and req_ready=0; resp_ready=1 → back to IDLE on the next edge.
REQ-036 Assert ld_en with req_valid=1 in IDLE → req_ready=0 and no accept; the fetch is accepted on the first cycle with ld_en=0.
REQ-037 Assert reset for 1 cycle while in WAIT → resp_valid stays 0 and the next fetch completes normally with correct data.
REQ-038 Sweep LATENCY over 1, 2 and 4 with back-to-back fetches at 0, 4 and 8 → each response arrives exactly LATENCY edges after its accept, in order.
